// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: walks the rows, waits for the columns to settle,
// debounces press and release, and hands one key event per press to the display stage.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_sync,
    output logic [3:0] r_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down
);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_REPORT   = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       code_q, code_d;
    logic             col_one_hot;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [3:0] col_oh);
        logic [1:0] col;
        logic [3:0] code;
        col = 2'd0;
        if (col_oh[1]) col = 2'd1;
        if (col_oh[2]) col = 2'd2;
        if (col_oh[3]) col = 2'd3;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hF;  4'hD: code = 4'h0;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign col_one_hot = (col_sync != 4'b0) && ((col_sync & (col_sync - 4'd1)) == 4'b0);

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first so no path infers a latch.
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        code_d  = code_q;
        case (state_q)
            S_SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (col_one_hot) begin
                        col_d   = col_sync;
                        state_d = S_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DEBOUNCE: begin
                if (col_sync != col_q) begin
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    code_d  = key_lookup(row_q, col_q);
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_REPORT: begin
                // Columns are ignored here so an early release cannot cancel a debounced press.
                if (key_ready) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (col_sync != 4'b0) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                row_d   = 2'd0;
                cnt_d   = '0;
                state_d = S_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_SCAN;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            col_q   <= 4'b0;
            code_q  <= 4'h0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            code_q  <= code_d;
        end
    end

    assign r_sel     = ~(4'b0001 << row_q);
    assign key_code  = code_q;
    assign key_valid = (state_q == S_REPORT);
    assign key_down  = (state_q == S_REPORT) || (state_q == S_HOLD);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model answers the row drive,
// a scoreboard queue holds expected key codes and a monitor checks each handshake.
module tb_keypad_scan_ctrl;

    localparam int SETTLE = 2;
    localparam int DEB    = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_sync;
    logic [3:0] r_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;

    logic       press_en;
    logic [1:0] press_row;
    logic [3:0] press_cols;
    logic       glitch;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col_sync (col_sync),
        .r_sel    (r_sel),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Pressed key closes its column(s) only while its row is driven low.
    always_comb col_sync = (press_en && !glitch && (r_sel[press_row] == 1'b0)) ? press_cols : 4'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_row_start(input logic [3:0] rs, input int max_cyc, output bit ok);
        logic [3:0] prev;
        ok   = 1'b0;
        prev = r_sel;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (r_sel == rs && prev != rs) begin
                ok = 1'b1;
                break;
            end
            prev = r_sel;
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got key_code %0h expected no event", key_code);
                end else begin
                    e = exp_q.pop_front();
                    check("event_code", {28'b0, key_code}, {28'b0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stimulus
        bit         ok;
        bit         bad;
        int         run;
        int         max_run;
        logic [3:0] ex;

        reset      = 1'b0;
        key_ready  = 1'b0;
        press_en   = 1'b0;
        press_row  = 2'd0;
        press_cols = 4'b0;
        glitch     = 1'b0;

        // Reset values, then idle scan sequence
        repeat (3) tick();
        check("rst_r_sel", r_sel, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_down", key_down, 1'b0);
        reset = 1'b1;
        #1;
        check("idle_r_sel_0", r_sel, 4'b1110);
        bad = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            ex = ~(4'b0001 << ((i / 2) % 4));
            check($sformatf("idle_r_sel_%0d", i), r_sel, ex);
            if (key_valid) bad = 1'b1;
        end
        check("idle_no_valid", bad, 1'b0);

        // Key 6 (row1 col2) held 200 cycles with consumer ready
        key_ready  = 1'b1;
        press_row  = 2'd1;
        press_cols = 4'b0100;
        press_en   = 1'b1;
        exp_q.push_back(4'h6);
        repeat (200) tick();
        check("hold6_r_sel", r_sel, 4'b1101);
        check("hold6_key_down", key_down, 1'b1);
        check("hold6_valid_low", key_valid, 1'b0);
        press_en = 1'b0;
        repeat (7) tick();
        check("release6_down_held", key_down, 1'b1);
        tick();
        check("release6_down_off", key_down, 1'b0);
        check("release6_next_row", r_sel, 4'b1011);

        // Row0 col0 press with a one-cycle glitch at debounce count 4
        press_row  = 2'd0;
        press_cols = 4'b0001;
        press_en   = 1'b1;
        wait_row_start(4'b1110, 20, ok);
        check("glitch_row0_found", ok, 1'b1);
        repeat (6) tick();
        glitch = 1'b1;
        tick();
        glitch   = 1'b0;
        press_en = 1'b0;
        check("glitch_abort_r_sel", r_sel, 4'b1101);
        check("glitch_no_valid", key_valid, 1'b0);
        check("glitch_no_down", key_down, 1'b0);
        repeat (20) tick();

        // Multi-hot columns in row0 never leave scan
        press_row  = 2'd0;
        press_cols = 4'b0011;
        press_en   = 1'b1;
        run     = 0;
        max_run = 0;
        bad     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (r_sel == 4'b1110) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (key_valid || key_down) bad = 1'b1;
        end
        press_en = 1'b0;
        check("multihot_row0_dwell", max_run, SETTLE);
        check("multihot_no_event", bad, 1'b0);

        // Key 0 (row3 col1) with consumer stalled 100 cycles, released early
        key_ready  = 1'b0;
        press_row  = 2'd3;
        press_cols = 4'b0010;
        press_en   = 1'b1;
        exp_q.push_back(4'h0);
        wait_valid(60, ok);
        check("key0_valid_seen", ok, 1'b1);
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 20) press_en = 1'b0;
            tick();
            if (!(key_valid === 1'b1 && key_code === 4'h0 && key_down === 1'b1)) bad = 1'b1;
        end
        check("key0_report_stable", bad, 1'b0);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("key0_valid_dropped", key_valid, 1'b0);
        check("key0_hold_down", key_down, 1'b1);
        repeat (7) tick();
        check("key0_hold_down_7", key_down, 1'b1);
        tick();
        check("key0_hold_exit", key_down, 1'b0);
        check("key0_next_row", r_sel, 4'b1110);

        // Asynchronous reset while an event is pending (row2 col3 = C)
        press_row  = 2'd2;
        press_cols = 4'b1000;
        press_en   = 1'b1;
        wait_valid(60, ok);
        check("keyC_valid_seen", ok, 1'b1);
        check("keyC_code", key_code, 4'hC);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", key_valid, 1'b0);
        check("async_rst_code", key_code, 4'h0);
        check("async_rst_r_sel", r_sel, 4'b1110);
        check("async_rst_down", key_down, 1'b0);
        press_en = 1'b0;
        tick();
        reset     = 1'b1;
        key_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_valid) bad = 1'b1;
        end
        check("async_rst_discarded", bad, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
